// File: rtl/i2c_pkg.sv
// Shared definitions for the simplified 4-bit I2C link (slave and master sides).
package i2c_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 4;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WRITE,
        WRITE_ACK,
        READ,
        READ_ACK,
        WAIT_STOP
    } i2c_state_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// Two-flop synchronizers for scl/sda plus SCL edge and START/STOP detection.
module i2c_bus_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start_det,
    output logic o_stop_det
);

    logic [1:0] r_scl_sync;
    logic [1:0] r_sda_sync;
    logic       r_scl_prev;
    logic       r_sda_prev;

    // Preset to 1 so leaving reset on an idle bus never looks like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[0], i_scl};
            r_sda_sync <= {r_sda_sync[0], i_sda};
            r_scl_prev <= r_scl_sync[1];
            r_sda_prev <= r_sda_sync[1];
        end
    end

    assign o_sda       = r_sda_sync[1];
    assign o_scl_rise  =  r_scl_sync[1] & ~r_scl_prev;
    assign o_scl_fall  = ~r_scl_sync[1] &  r_scl_prev;
    assign o_start_det =  r_scl_sync[1] &  r_scl_prev &  r_sda_prev & ~r_sda_sync[1];
    assign o_stop_det  =  r_scl_sync[1] &  r_scl_prev & ~r_sda_prev &  r_sda_sync[1];

endmodule

// File: rtl/i2c_slave.sv
// I2C responder: address match with ACK, multi-word writes, tx_data reads with
// master ACK/NACK handling. Oversampled on clk; only ever pulls sda low.
module i2c_slave
    import i2c_pkg::*;
#(
    parameter int                ADDR_W     = DEF_ADDR_W,
    parameter int                DATA_W     = DEF_DATA_W,
    parameter logic [ADDR_W-1:0] SLAVE_ADDR = ADDR_W'(4'b1100)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              scl,
    inout  wire               sda,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_req,
    output logic              busy,
    output logic              rw
);

    localparam int BITS_MAX = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;
    localparam int CNT_W    = $clog2(BITS_MAX + 1);
    localparam int SHIFT_W  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W);

    logic w_sda, w_scl_rise, w_scl_fall, w_start_det, w_stop_det;

    i2c_bus_sync u_sync (
        .clk        (clk),
        .rst_n      (reset),
        .i_scl      (scl),
        .i_sda      (sda),
        .o_sda      (w_sda),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_start_det(w_start_det),
        .o_stop_det (w_stop_det)
    );

    i2c_state_e         r_state,    w_state;
    logic [CNT_W-1:0]   r_bit_cnt,  w_bit_cnt;
    logic [SHIFT_W-1:0] r_shift,    w_shift;
    logic [DATA_W-1:0]  r_tx_shift, w_tx_shift;
    logic [DATA_W-1:0]  r_rx_data,  w_rx_data;
    logic r_sda_low, w_sda_low;
    logic r_rx_valid, w_rx_valid;
    logic r_tx_req, w_tx_req;
    logic r_busy, w_busy;
    logic r_rw, w_rw;
    logic w_load;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_tx_shift <= '0;
            r_rx_data  <= '0;
            r_sda_low  <= 1'b0;
            r_rx_valid <= 1'b0;
            r_tx_req   <= 1'b0;
            r_busy     <= 1'b0;
            r_rw       <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_bit_cnt  <= w_bit_cnt;
            r_shift    <= w_shift;
            r_tx_shift <= w_tx_shift;
            r_rx_data  <= w_rx_data;
            r_sda_low  <= w_sda_low;
            r_rx_valid <= w_rx_valid;
            r_tx_req   <= w_tx_req;
            r_busy     <= w_busy;
            r_rw       <= w_rw;
        end
    end

    always_comb begin
        // NOTE: every next value gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
        w_state    = r_state;
        w_bit_cnt  = r_bit_cnt;
        w_shift    = r_shift;
        w_tx_shift = r_tx_shift;
        w_rx_data  = r_rx_data;
        w_sda_low  = r_sda_low;
        w_busy     = r_busy;
        w_rw       = r_rw;
        w_rx_valid = 1'b0;
        w_tx_req   = 1'b0;
        w_load     = 1'b0;

        if (w_stop_det) begin
            w_state   = IDLE;
            w_busy    = 1'b0;
            w_sda_low = 1'b0;
        end else if (w_start_det) begin
            w_state   = ADDR;
            w_bit_cnt = '0;
            w_sda_low = 1'b0;
        end else begin
            unique case (r_state)
                ADDR: if (w_scl_rise) begin
                    w_shift   = {r_shift[SHIFT_W-2:0], w_sda};
                    w_bit_cnt = r_bit_cnt + 1'b1;
                    // The last bit is R/W; the address is already in the shifter.
                    if (r_bit_cnt == ADDR_LAST) begin
                        if (r_shift[ADDR_W-1:0] == SLAVE_ADDR) begin
                            w_rw    = w_sda;
                            w_busy  = 1'b1;
                            w_state = ADDR_ACK;
                        end else begin
                            w_state = WAIT_STOP;
                        end
                    end
                end
                ADDR_ACK: if (w_scl_fall) begin
                    if (!r_sda_low) begin
                        w_sda_low = 1'b1;
                    end else if (r_rw == RW_READ) begin
                        w_load = 1'b1;
                    end else begin
                        w_sda_low = 1'b0;
                        w_bit_cnt = '0;
                        w_state   = WRITE;
                    end
                end
                WRITE: begin
                    if (w_scl_rise) begin
                        w_shift   = {r_shift[SHIFT_W-2:0], w_sda};
                        w_bit_cnt = r_bit_cnt + 1'b1;
                    end else if (w_scl_fall && r_bit_cnt == DATA_LAST) begin
                        w_rx_data  = r_shift[DATA_W-1:0];
                        w_rx_valid = 1'b1;
                        w_sda_low  = 1'b1;
                        w_state    = WRITE_ACK;
                    end
                end
                WRITE_ACK: if (w_scl_fall) begin
                    w_sda_low = 1'b0;
                    w_bit_cnt = '0;
                    w_state   = WRITE;
                end
                READ: if (w_scl_fall) begin
                    if (r_bit_cnt == DATA_LAST) begin
                        w_sda_low = 1'b0;
                        w_state   = READ_ACK;
                    end else begin
                        w_tx_shift = {r_tx_shift[DATA_W-2:0], r_tx_shift[DATA_W-1]};
                        w_sda_low  = ~r_tx_shift[DATA_W-2];
                        w_bit_cnt  = r_bit_cnt + 1'b1;
                    end
                end
                READ_ACK: begin
                    if (w_scl_rise && w_sda) begin
                        w_state = WAIT_STOP;
                    end else if (w_scl_fall) begin
                        w_load = 1'b1;
                    end
                end
                default: ;
            endcase

            // Word load shared by the address ACK and every master ACK on reads.
            if (w_load) begin
                w_tx_shift = tx_data;
                w_tx_req   = 1'b1;
                w_sda_low  = ~tx_data[DATA_W-1];
                w_bit_cnt  = CNT_W'(1);
                w_state    = READ;
            end
        end
    end

    assign sda      = r_sda_low ? 1'b0 : 1'bz;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign tx_req   = r_tx_req;
    assign busy     = r_busy;
    assign rw       = r_rw;

endmodule

// File: tb/tb_i2c_slave.sv
// Bus-level master driving i2c_slave; transaction model feeds scoreboard queues.
module tb_i2c_slave;
    import i2c_pkg::*;

    localparam logic [3:0] SLAVE_ADDR = 4'b1100;
    localparam int         H          = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl;
    logic       m_sda_low;
    wire        sda;
    logic [3:0] tx_data;
    logic [3:0] rx_data;
    logic       rx_valid, tx_req, busy, rw;

    pullup (sda);
    assign sda = m_sda_low ? 1'b0 : 1'bz;

    i2c_slave #(.ADDR_W(4), .DATA_W(4), .SLAVE_ADDR(SLAVE_ADDR)) dut (
        .clk     (clk),
        .reset   (reset),
        .scl     (scl),
        .sda     (sda),
        .tx_data (tx_data),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .tx_req  (tx_req),
        .busy    (busy),
        .rw      (rw)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    logic [3:0] exp_rx[$];
    logic [3:0] exp_tx[$];
    logic [3:0] wr_words[3];
    logic [3:0] rd_words[3];
    logic [3:0] model_rx_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every output pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (reset) begin
            if (rx_valid) begin
                if (exp_rx.size() == 0) check("rx_valid_unexpected", rx_valid, 1'b0);
                else                    check("rx_data", rx_data, exp_rx.pop_front());
            end
            if (tx_req) begin
                if (exp_tx.size() == 0) check("tx_req_unexpected", tx_req, 1'b0);
                else                    check("tx_req_word", tx_data, exp_tx.pop_front());
            end
        end
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, output logic obs);
        m_sda_low = ~b;
        clks(4);
        scl = 1'b1;
        clks(H / 2);
        obs = sda;
        clks(H / 2);
        scl = 1'b0;
        clks(4);
    endtask

    task automatic bus_start();
        m_sda_low = 1'b0;
        clks(4);
        scl = 1'b1;
        clks(H);
        m_sda_low = 1'b1;
        clks(H);
        scl = 1'b0;
        clks(4);
    endtask

    task automatic bus_stop();
        m_sda_low = 1'b1;
        clks(4);
        scl = 1'b1;
        clks(H);
        m_sda_low = 1'b0;
        clks(H);
    endtask

    task automatic send_addr(input logic [3:0] addr, input logic rwb, output logic matched);
        logic obs;
        matched = (addr == SLAVE_ADDR);
        for (int i = 3; i >= 0; i--) send_bit(addr[i], obs);
        send_bit(rwb, obs);
        send_bit(1'b1, obs);
        check("addr_ack", obs, matched ? 1'b0 : 1'b1);
        check("busy_after_addr", busy, matched);
        if (matched) check("rw_latched", rw, rwb);
    endtask

    task automatic finish_xfer();
        bus_stop();
        clks(6);
        check("busy_after_stop", busy, 1'b0);
        check("state_after_stop", dut.r_state, IDLE);
        check("rx_data_hold", rx_data, model_rx_last);
        check("rx_missing", exp_rx.size(), 0);
        check("tx_req_missing", exp_tx.size(), 0);
    endtask

    // stop_bits >= 0 aborts the last word with a STOP after that many data bits.
    task automatic write_xfer(input logic [3:0] addr, input int nw, input int stop_bits);
        logic matched, obs, partial;
        int   nb;
        bus_start();
        send_addr(addr, RW_WRITE, matched);
        for (int w = 0; w < nw; w++) begin
            partial = (stop_bits >= 0) && (w == nw - 1);
            nb      = partial ? stop_bits : 4;
            if (matched && !partial) exp_rx.push_back(wr_words[w]);
            for (int i = 0; i < nb; i++) send_bit(wr_words[w][3-i], obs);
            if (!partial) begin
                send_bit(1'b1, obs);
                check("data_ack", obs, matched ? 1'b0 : 1'b1);
                if (matched) model_rx_last = wr_words[w];
            end
        end
        finish_xfer();
    endtask

    // The master ACKs every word but the last, which it NACKs.
    task automatic read_xfer(input logic [3:0] addr, input int nw);
        logic matched, obs;
        tx_data = rd_words[0];
        if (addr == SLAVE_ADDR) exp_tx.push_back(rd_words[0]);
        bus_start();
        send_addr(addr, RW_READ, matched);
        for (int w = 0; w < nw; w++) begin
            for (int i = 0; i < 4; i++) begin
                send_bit(1'b1, obs);
                check("read_bit", obs, matched ? rd_words[w][3-i] : 1'b1);
            end
            if (w < nw - 1) begin
                tx_data = rd_words[w+1];
                if (matched) exp_tx.push_back(rd_words[w+1]);
                send_bit(1'b0, obs);
            end else begin
                send_bit(1'b1, obs);
            end
        end
        check("state_after_nack", dut.r_state, WAIT_STOP);
        finish_xfer();
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       matched;
        logic [3:0] addr;
        int         nw;

        reset         = 1'b0;
        scl           = 1'b1;
        m_sda_low     = 1'b0;
        tx_data       = '0;
        model_rx_last = '0;
        clks(3);
        check("reset_sda", sda, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_rw", rw, 1'b0);
        check("reset_rx_data", rx_data, 4'h0);
        check("reset_rx_valid", rx_valid, 1'b0);
        check("reset_tx_req", tx_req, 1'b0);
        check("reset_state", dut.r_state, IDLE);
        reset = 1'b1;
        clks(4);

        wr_words[0] = 4'b0101;
        write_xfer(SLAVE_ADDR, 1, -1);

        wr_words[0] = 4'b0011;
        write_xfer(4'b1010, 1, -1);

        rd_words[0] = 4'b1001;
        read_xfer(SLAVE_ADDR, 1);

        wr_words[0] = 4'b0101;
        wr_words[1] = 4'b1110;
        write_xfer(SLAVE_ADDR, 2, -1);

        wr_words[0] = 4'b0110;
        write_xfer(SLAVE_ADDR, 1, 2);

        for (int t = 0; t < 20; t++) begin
            addr = ($urandom_range(0, 1) == 1) ? SLAVE_ADDR : 4'($urandom);
            nw   = $urandom_range(1, 3);
            for (int k = 0; k < 3; k++) begin
                wr_words[k] = 4'($urandom);
                rd_words[k] = 4'($urandom);
            end
            if ($urandom_range(0, 1) == 1)
                write_xfer(addr, nw, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1);
            else
                read_xfer(addr, nw);
        end

        wr_words[0] = 4'b1011;
        write_xfer(SLAVE_ADDR, 1, -1);

        // Reset while the slave is pulling sda low for a read MSB of 0.
        rd_words[0] = 4'b0011;
        tx_data     = 4'b0011;
        exp_tx.push_back(4'b0011);
        bus_start();
        send_addr(SLAVE_ADDR, RW_READ, matched);
        m_sda_low = 1'b0;
        clks(4);
        scl = 1'b1;
        clks(2);
        check("sda_driven_in_read", sda, 1'b0);
        check("state_read", dut.r_state, READ);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("async_reset_sda", sda, 1'b1);
        check("async_reset_busy", busy, 1'b0);
        check("async_reset_rw", rw, 1'b0);
        check("async_reset_rx_data", rx_data, 4'h0);
        check("async_reset_rx_valid", rx_valid, 1'b0);
        check("async_reset_tx_req", tx_req, 1'b0);
        check("async_reset_state", dut.r_state, IDLE);
        model_rx_last = '0;
        exp_rx.delete();
        exp_tx.delete();
        clks(4);
        reset = 1'b1;
        clks(4);

        wr_words[0] = 4'b1001;
        write_xfer(SLAVE_ADDR, 1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- Responder end of the team's simplified I2C link, opposite the I2C master: 4-bit address, 4-bit data words, MSB first.
- Sits on the shared open-drain `sda`/`scl` pair. Everything is oversampled on the single system clock; SCL is input-only.
- Decodes START/STOP, matches its own address and ACKs it.
- Write transfers: shifts data in and ACKs each word.
- Read transfers: shifts `tx_data` out and checks the master's ACK/NACK.

Parameters:
- `SLAVE_ADDR`, `4'b1100`, address this slave answers to.
- `ADDR_W`, 4, address bits on the bus.
- `DATA_W`, 4, bits per data word.

Ports:
- `clk` input 1: system clock; all logic on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `scl` input 1: bus clock from the master.
- `sda` inout 1: open-drain data. The block only ever drives 0 or releases (Z).
- `tx_data` input `DATA_W`: word returned on reads. Sampled when `tx_req` pulses.
- `rx_data` output `DATA_W`: last word received on a write.
- `rx_valid` output 1: one-clk pulse when `rx_data` updates.
- `tx_req` output 1: one-clk pulse when `tx_data` is loaded into the shifter.
- `busy` output 1: high from an address match until STOP.
- `rw` output 1: R/W bit of the current transfer (1 = read).

Behaviour:
- Reset: asynchronous on `reset`=0. State=IDLE, `sda` released (Z), `rx_data`=0, `rx_valid`=0, `tx_req`=0, `busy`=0, `rw`=0. Synchronizers preset to 1 (idle bus). Applies mid-transfer too: `sda` is released in the same clk period `reset` falls.
- Input sync: `scl` and `sda` each pass through 2 flops. Edges are detected from the synced value vs. its previous value. Required: SCL high and low phases ≥ 4 clk each.
- START: synced SDA falls while synced SCL high. From any state → ADDR, bit counter cleared, `sda` released.
- STOP: synced SDA rises while synced SCL high. From any state → IDLE, `busy`=0, `sda` released.
- Sampling and driving: the slave samples SDA on each detected SCL rising edge and changes its SDA drive only on a detected SCL falling edge. A START or STOP seen in the same cycle as an SCL edge takes priority.
- State machine:
  - IDLE: waits for START.
  - ADDR: shifts `ADDR_W`+1 bits (address MSB first, then R/W).
    - After the last rising edge, compare the address to `SLAVE_ADDR`.
    - Match: latch `rw`, `busy`=1, → ADDR_ACK.
    - Mismatch: → WAIT_STOP. `sda` is never driven.
  - ADDR_ACK: drive `sda`=0 from the next SCL falling edge until the following falling edge.
    - At that release edge, if `rw`=0 → WRITE.
    - If `rw`=1: load `tx_data`, pulse `tx_req` for 1 clk, drive the MSB (0→drive low, 1→release), → READ.
  - WRITE: shifts `DATA_W` bits on rising edges. On the next falling edge:
    - `rx_data` ← shifter and `rx_valid` pulses for 1 clk.
    - `sda` driven low (ACK), → WRITE_ACK.
  - WRITE_ACK: releases `sda` at the next falling edge, → WRITE. Multiple words are accepted until STOP.
  - READ: the next bit is presented on each falling edge. After the LSB has been on the bus for a full SCL high, release `sda` at the falling edge → READ_ACK.
  - READ_ACK: sample SDA on the rising edge.
    - 0 (ACK): at the next falling edge reload `tx_data`, pulse `tx_req`, drive the MSB, → READ.
    - 1 (NACK): → WAIT_STOP.
  - WAIT_STOP: `sda` released, ignores everything except START/STOP.
- Boundary cases:
  - START inside ADDR (repeated start): restarts the address phase; `busy` holds its value until a new match or STOP.
  - STOP mid-word: the partial word is discarded and `rx_valid` does not fire.
  - SCL stalled high or low: state holds indefinitely, with no timeout.

Decomposition:
- Shared package `i2c_pkg`:
  - state enumeration (IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP);
  - `ADDR_W`/`DATA_W` defaults;
  - R/W encoding constants.
- One sub-module `i2c_bus_sync`: 2-flop synchronizers for `scl`/`sda` plus outputs `scl_rise`, `scl_fall`, `start_det`, `stop_det`. Also reusable by the master.

Test Plan:
- Write match: START, addr 1100, R/W=0, data 0101, STOP.
  - Slave pulls `sda` low during both ACK bits.
  - `rx_data`=0101 with exactly one `rx_valid` pulse.
  - `busy`=1 → 0 after STOP.
- Address mismatch: START, addr 1010, R/W=0.
  - `sda` never driven; `busy`=0; `rx_valid` never pulses.
- Read: START, addr 1100, R/W=1, `tx_data`=1001, master NACK, STOP.
  - Bus carries 1,0,0,1 on four SCL highs; one `tx_req` pulse.
  - State WAIT_STOP, then IDLE after STOP.
- Multi-word: write 0101 then 1110 without STOP, master ACK continues, then STOP.
  - Two `rx_valid` pulses with `rx_data` 0101 then 1110.
  - Slave ACKs three times (address + 2 words).
- STOP mid-word after 2 data bits: IDLE, no `rx_valid`, `rx_data` keeps its previous value.
- Asynchronous reset asserted during READ while `sda` is driven low: `sda`=Z and all outputs at reset values within the same clk period. The next START is handled normally.
